// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// i2c_slave_regfile
// I2C slave that exposes NUM_REGS 8-bit control registers. It has a
// sub-address pointer, auto-increment, read-back and write strobes. SCL and
// SDA are oversampled on clk, so START and STOP detection uses no
// combinational path from the pins.
// Ports:
//   clk     system clock (at least 20x SCL)
//   rst     asynchronous active-high reset
//   scl_i   raw SCL pin level
//   sda_i   raw SDA pin level
//   sda_oe  1 = pull SDA low, 0 = release
//   regs_o  register contents; register k is bits [8k+7:8k]
//   wr_stb  one-cycle pulse after a data byte is committed
//   wr_idx  index of the committed register, valid with wr_stb
//   busy    high from an addressed START until STOP
module i2c_slave_regfile #(
  parameter logic [6:0]  I2C_ADR  = 7'h27,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned FILT     = 3,
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_stb,
  output logic [IDX_W-1:0]      wr_idx,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // Bit 0 carries SCL and bit 1 carries SDA throughout the conditioning path.
  logic [1:0]       sync1, sync2, clean, clean_d;
  logic [CNT_W-1:0] fcnt [2];

  // Two-flop synchroniser, then a filter that adopts a new level only after
  // FILT consecutive samples disagree with the current clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      clean   <= 2'b11;
      clean_d <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1   <= {sda_i, scl_i};
      sync2   <= sync1;
      clean_d <= clean;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == clean[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          clean[i] <= sync2[i];
          fcnt[i]  <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Bus events derived from the registered clean levels.
  logic scl_rise_c, scl_fall_c, start_c, stop_c, sda_c;
  assign sda_c      = clean[1];
  assign scl_rise_c = clean[0] & ~clean_d[0];
  assign scl_fall_c = ~clean[0] & clean_d[0];
  assign start_c    = clean[0] & clean_d[0] & clean_d[1] & ~clean[1];
  assign stop_c     = clean[0] & clean_d[0] & ~clean_d[1] & clean[1];

  state_t           state;
  logic [7:0]       sr;
  logic [3:0]       bit_cnt;
  logic             rw;
  logic             mack;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       regs [NUM_REGS];

  // Explicit wrap compare; NUM_REGS need not be a power of two.
  logic [IDX_W-1:0] ptr_inc_c;
  assign ptr_inc_c = (ptr == IDX_LAST) ? '0 : ptr + IDX_W'(1);

  // Protocol FSM. SDA is sampled on scl_rise, and sda_oe is updated on scl_fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      rw      <= 1'b0;
      mack    <= 1'b0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_idx  <= '0;
      busy    <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (state == ADDR_ACK) busy <= 1'b1;

      if (stop_c) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_c) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR, SUB, WDATA: begin
            if (scl_rise_c) begin
              sr      <= {sr[6:0], sda_c};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall_c && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              case (state)
                ADDR: begin
                  if (sr[7:1] == I2C_ADR) begin
                    rw     <= sr[0];
                    sda_oe <= 1'b1;
                    state  <= ADDR_ACK;
                  end else begin
                    state <= IGNORE;
                  end
                end
                SUB: begin
                  // The full 8-bit sub-address is compared so out-of-range values are refused.
                  if ({1'b0, sr} < 9'(NUM_REGS)) begin
                    ptr    <= IDX_W'(sr);
                    sda_oe <= 1'b1;
                    state  <= SUB_ACK;
                  end else begin
                    state <= IGNORE;
                  end
                end
                default: begin
                  sda_oe <= 1'b1;
                  state  <= WDATA_ACK;
                end
              endcase
            end
          end

          ADDR_ACK: begin
            if (scl_fall_c) begin
              if (rw) begin
                sr     <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= SUB;
              end
            end
          end

          SUB_ACK: begin
            if (scl_fall_c) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end

          WDATA_ACK: begin
            if (scl_fall_c) begin
              regs[ptr] <= sr;
              wr_stb    <= 1'b1;
              wr_idx    <= ptr;
              ptr       <= ptr_inc_c;
              sda_oe    <= 1'b0;
              state     <= WDATA;
            end
          end

          RDATA: begin
            if (scl_rise_c) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall_c) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= RDATA_ACK;
              end else begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end

          RDATA_ACK: begin
            if (scl_rise_c) begin
              mack <= ~sda_c;
            end else if (scl_fall_c) begin
              // The pointer advances whether the master sends ACK or NACK.
              ptr <= ptr_inc_c;
              if (mack) begin
                sr     <= regs[ptr_inc_c];
                sda_oe <= ~regs[ptr_inc_c][7];
                state  <= RDATA;
              end else begin
                state <= IGNORE;
              end
            end
          end

          IGNORE: sda_oe <= 1'b0;

          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
// Directed bench for i2c_slave_regfile, using the default parameters
// (address 0x27, 4 registers, FILT=3). The bench acts as an open-drain
// I2C master and checks acknowledges, read data, register contents,
// write strobes, busy, glitch rejection and asynchronous reset.
module tb_i2c_slave_regfile;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic [31:0] regs_o;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        busy;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_m),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .regs_o (regs_o),
    .wr_stb (wr_stb),
    .wr_idx (wr_idx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write-strobe log and sda_oe activity counter.
  logic [1:0] stb_log [64];
  int         stb_n = 0;
  int         oe_cnt = 0;
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_log[stb_n % 64] = wr_idx;
      stb_n = stb_n + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; idle(Q);
    scl_m = 1'b1; idle(2*Q);
    sda_m = 1'b0; idle(2*Q);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; idle(Q);
    scl_m = 1'b1; idle(2*Q);
    sda_m = 1'b1; idle(2*Q);
  endtask

  // Optional SCL glitch of glen clks during the low phase of bit glitch_at.
  task automatic write_byte(input logic [7:0] b, input int glitch_at, input int glen,
                            output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      if (i == glitch_at) begin
        idle(3);
        scl_m = 1'b1; idle(glen);
        scl_m = 1'b0; idle(Q - 3 - glen);
      end else begin
        idle(Q);
      end
      scl_m = 1'b1; idle(2*Q);
      scl_m = 1'b0; idle(Q);
    end
    sda_m = 1'b1; idle(Q);
    scl_m = 1'b1; idle(Q);
    ack = ~sda_bus;
    idle(Q);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; idle(Q);
      scl_m = 1'b1; idle(Q);
      d[i] = sda_bus;
      idle(Q);
      scl_m = 1'b0; idle(Q);
    end
    sda_m = ~m_ack; idle(Q);
    scl_m = 1'b1; idle(2*Q);
    scl_m = 1'b0; idle(Q);
  endtask

  logic       ack;
  logic       ack_all;
  logic [7:0] rd;
  int         oe_mark;

  initial begin
    // Reset state
    idle(5);
    rst = 1'b0;
    idle(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_regs",   regs_o,      32'h0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);

    // T1: sub 0x02, data A5 3C
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); chk("t1_adr_ack", 32'(ack), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    write_byte(8'h02, -1, 0, ack); chk("t1_sub_ack", 32'(ack), 32'd1);
    write_byte(8'hA5, -1, 0, ack); chk("t1_d0_ack", 32'(ack), 32'd1);
    write_byte(8'h3C, -1, 0, ack); chk("t1_d1_ack", 32'(ack), 32'd1);
    i2c_stop();
    idle(10);
    chk("t1_regs", regs_o, 32'h3CA5_0000);
    chk("t1_stb_n", 32'(stb_n), 32'd2);
    chk("t1_idx0", 32'(stb_log[0]), 32'd2);
    chk("t1_idx1", 32'(stb_log[1]), 32'd3);
    chk("t1_busy_after_stop", 32'(busy), 32'd0);

    // T2: pointer wrap from 3 to 0
    ack_all = 1'b1;
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); ack_all &= ack;
    write_byte(8'h03, -1, 0, ack); ack_all &= ack;
    write_byte(8'h11, -1, 0, ack); ack_all &= ack;
    write_byte(8'h22, -1, 0, ack); ack_all &= ack;
    i2c_stop();
    idle(10);
    chk("t2_acks", 32'(ack_all), 32'd1);
    chk("t2_regs", regs_o, 32'h11A5_0022);
    chk("t2_idx0", 32'(stb_log[2]), 32'd3);
    chk("t2_idx1", 32'(stb_log[3]), 32'd0);

    // T3: load 01..04, then sub 0x01, repeated START, read three bytes
    ack_all = 1'b1;
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); ack_all &= ack;
    write_byte(8'h00, -1, 0, ack); ack_all &= ack;
    write_byte(8'h01, -1, 0, ack); ack_all &= ack;
    write_byte(8'h02, -1, 0, ack); ack_all &= ack;
    write_byte(8'h03, -1, 0, ack); ack_all &= ack;
    write_byte(8'h04, -1, 0, ack); ack_all &= ack;
    i2c_stop();
    idle(10);
    chk("t3_load_acks", 32'(ack_all), 32'd1);
    chk("t3_regs", regs_o, 32'h0403_0201);
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); chk("t3_wadr_ack", 32'(ack), 32'd1);
    write_byte(8'h01, -1, 0, ack); chk("t3_sub_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'h4F, -1, 0, ack); chk("t3_radr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, rd); chk("t3_rd0", 32'(rd), 32'h02);
    read_byte(1'b1, rd); chk("t3_rd1", 32'(rd), 32'h03);
    read_byte(1'b0, rd); chk("t3_rd2", 32'(rd), 32'h04);
    oe_mark = oe_cnt;
    idle(30);
    chk("t3_release_after_nack", 32'(oe_cnt - oe_mark), 32'd0);
    i2c_stop();
    idle(10);
    chk("t3_regs_after_read", regs_o, 32'h0403_0201);

    // T4: foreign address, then out-of-range sub-address
    oe_mark = oe_cnt;
    i2c_start();
    write_byte(8'h50, -1, 0, ack); chk("t4_bad_adr_nack", 32'(ack), 32'd0);
    write_byte(8'h00, -1, 0, ack); chk("t4_bad_adr_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    idle(10);
    chk("t4_bad_adr_no_oe", 32'(oe_cnt - oe_mark), 32'd0);
    chk("t4_bad_adr_busy", 32'(busy), 32'd0);
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); chk("t4_adr_ack", 32'(ack), 32'd1);
    oe_mark = oe_cnt;
    write_byte(8'h07, -1, 0, ack); chk("t4_sub_nack", 32'(ack), 32'd0);
    write_byte(8'h99, -1, 0, ack); chk("t4_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    idle(10);
    chk("t4_bad_sub_no_oe", 32'(oe_cnt - oe_mark), 32'd0);
    chk("t4_regs", regs_o, 32'h0403_0201);
    chk("t4_stb_n", 32'(stb_n), 32'd8);

    // T5: short SCL glitches inside data bytes
    ack_all = 1'b1;
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); ack_all &= ack;
    write_byte(8'h00, -1, 0, ack); ack_all &= ack;
    write_byte(8'h5A,  4, 1, ack); ack_all &= ack;
    write_byte(8'hC3,  1, 2, ack); ack_all &= ack;
    i2c_stop();
    idle(10);
    chk("t5_acks", 32'(ack_all), 32'd1);
    chk("t5_regs", regs_o, 32'h0403_C35A);
    chk("t5_stb_n", 32'(stb_n), 32'd10);

    // T6: reset while the slave drives a read bit (reg2=0x03, MSB 0)
    i2c_start();
    write_byte(8'h4F, -1, 0, ack); chk("t6_radr_ack", 32'(ack), 32'd1);
    chk("t6_oe_before_rst", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_oe_in_rst", 32'(sda_oe), 32'd0);
    chk("t6_regs_in_rst", regs_o, 32'h0);
    chk("t6_busy_in_rst", 32'(busy), 32'd0);
    idle(3);
    rst = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    idle(20);

    // Recovery after reset
    ack_all = 1'b1;
    i2c_start();
    write_byte(8'h4E, -1, 0, ack); ack_all &= ack;
    write_byte(8'h02, -1, 0, ack); ack_all &= ack;
    write_byte(8'h77, -1, 0, ack); ack_all &= ack;
    i2c_stop();
    idle(10);
    chk("t6_recover_acks", 32'(ack_all), 32'd1);
    chk("t6_recover_regs", regs_o, 32'h0077_0000);
    chk("t6_recover_idx", 32'(stb_log[10]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C slave exposing a bank of `NUM_REGS` 8-bit control registers with a sub-address pointer, auto-increment, read-back and write strobes. It is the next generation of the team's 8-bit I2C IO extender. SCL and SDA are oversampled on a single system clock, with no combinatorial start/stop loops. It sits between the board I2C bus pins (via an open-drain pad) and the fabric's control/config registers.

## Interface
- `I2C_ADR`, 7'h27, 7-bit slave address.
- `NUM_REGS`, 4, number of 8-bit registers; legal range 1..256.
- `FILT`, 3, glitch-filter length in clk cycles; legal range 1..15.
- `IDX_W`, derived: max(1, clog2(NUM_REGS)), register index width.
- `clk`  in  1  system clock; frequency must be ≥ 20× SCL.
- `rst`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  raw SCL pin level (asynchronous).
- `sda_i`  in  1  raw SDA pin level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. The pad ties the output data to 0.
- `regs_o`  out  8*NUM_REGS  register contents. Register k is bits [8k+7:8k].
- `wr_stb`  out  1  one-cycle pulse after each data byte is committed.
- `wr_idx`  out  IDX_W  index of the committed register; valid when `wr_stb`=1.
- `busy`  out  1  high from an addressed START until STOP.

## Operation
- **Input conditioning:** 2-flop synchroniser per line. A filter then updates the clean level only after `FILT` consecutive equal samples.
- **Clean-signal events:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - `scl_rise` and `scl_fall`: single-cycle pulses.
- **Sampling and driving:** SDA is sampled on `scl_rise`. `sda_oe` changes only on the clk after `scl_fall`, or on STOP/START/reset.
- **FSM states:** IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **Any state:**
  - START → ADDR. The bit counter is cleared.
  - STOP → IDLE. `sda_oe`=0.
- **ADDR:** shift 8 bits, MSB first.
  - Bits[7:1]==`I2C_ADR` → ADDR_ACK, driving ACK for the 9th clock.
  - Mismatch → IGNORE (no ACK).
  - The R/W bit is latched.
- **After ADDR_ACK:**
  - Write → SUB.
  - Read → RDATA, loading `regs[ptr]` into the shift register.
- **SUB:** the first write byte is the sub-address.
  - Value < `NUM_REGS`: `ptr` ← value, ACK → WDATA.
  - Otherwise: NACK → IGNORE, and `ptr` is unchanged.
- **WDATA:** 8 bits, then ACK.
  - On the 9th `scl_fall`: `regs[ptr]` ← byte, `wr_stb`=1, `wr_idx`=ptr.
  - `ptr` then increments, wrapping from NUM_REGS-1 to 0.
  - The FSM stays in WDATA for further bytes.
- **RDATA:** drive the inverse of each bit MSB first (`sda_oe`=~bit), then release for the master ACK bit (RDATA_ACK).
  - Master ACK (SDA low) → `ptr` increments with wrap, the next byte loads, back to RDATA.
  - Master NACK → `ptr` still increments, then IGNORE.
- **Repeated START:** `ptr` is retained. Write-sub-address / Sr / read therefore reads from the programmed address.
- **IGNORE:** `sda_oe`=0. Remains until START or STOP.
- **Width rules:**
  - `ptr` is IDX_W bits.
  - Wrap is an explicit compare to NUM_REGS-1; power-of-two is not assumed.
  - Sub-address compare is done on the full 8 bits.

## Timing
- **Reset values:**
  - `sda_oe`=0, `regs_o`=0, `wr_stb`=0, `wr_idx`=0, `busy`=0.
  - `ptr`=0, state IDLE, filters preset to 1 (idle bus).
- **Input latency:** raw pin to clean level is 2 + `FILT` clks.
- **SDA drive:** `sda_oe` updates exactly 1 clk after the `scl_fall` pulse. This gives hold time ≥ (3+`FILT`) clk past the pin edge.
- **Register commit:** `regs_o` and `wr_stb` update on the same clk, 1 clk after the 9th `scl_fall` of a data byte.
- **Read load:** the read byte is captured at the load point, on the `scl_fall` that ends ACK. A simultaneous fabric-side change does not apply; `regs_o` only changes via I2C.
- **`busy`:** rises the clk after ADDR_ACK is entered; falls the clk after STOP.
- **Reset mid-transfer:** immediate release of SDA, asynchronous. The next transaction needs a fresh START.
- **Glitch rejection:** pulses shorter than `FILT` clks are fully ignored.

## Test plan
- Write 0x4E, sub 0x02, data 0xA5, 0x3C, STOP (NUM_REGS=4) → reg2=0xA5, reg3=0x3C, two `wr_stb` with `wr_idx` 2 then 3, ACK on all four bytes.
- Write 0x4E, sub 0x03, data 0x11, 0x22 → reg3=0x11, reg0=0x22 (wrap); `wr_idx` 3 then 0.
- Write 0x4E, sub 0x01, Sr, 0x4F, read 3 bytes ACK/ACK/NACK with regs={0x01,0x02,0x03,0x04} → SDA shows 0x02, 0x03, 0x04; `sda_oe`=0 after NACK until STOP.
- Address 0x50 or sub 0x07 (≥NUM_REGS) → no ACK / NACK on sub, no register change, `sda_oe` stays 0.
- 1-clk glitch on SCL mid-byte with FILT=3 → ignored, byte received correctly; assert `rst` during a read bit with `sda_oe`=1 → `sda_oe`=0 same cycle, all regs 0.
